// File: rtl/conv1d_pkg.sv
// Shared types and constants for the Conv1D memory sequencer.
package conv1d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Bit positions inside every SRAM / L0 enable vector
    localparam int IDX_WEIGHT = 0;
    localparam int IDX_INPUT  = 1;
    localparam int IDX_OUTPUT = 2;

    // Issue -> Mac_Valid latency; also the depth DRAIN waits out
    localparam int PIPE_TAIL = 3;

endpackage

// File: rtl/conv1d_mem_sequencer_if.sv
// Control/address bus from the sequencer (master) to the Conv1D memory module (slave).
interface conv1d_mem_sequencer_if #(
    parameter int Weight_Addr_Width = 2,
    parameter int Input_Addr_Width  = 4,
    parameter int Output_Addr_Width = 4,
    parameter int L0_Addr_Width     = 1,
    parameter int Nums_SRAM         = 3,
    parameter int Nums_L0           = 3
);
    logic [Nums_SRAM-1:0]         Mem_Clear;
    logic [Nums_SRAM-1:0]         Mem_CS;
    logic [Nums_SRAM-1:0]         Mem_En_W;
    logic [Nums_SRAM-1:0]         Mem_En_R;
    logic [Weight_Addr_Width-1:0] Mem_Weight_Addr_Read;
    logic [Input_Addr_Width-1:0]  Mem_Input_Addr_Read;
    logic [Output_Addr_Width-1:0] Mem_Output_Addr_Write;

    logic [Nums_L0-1:0]           L0_Clear;
    logic [Nums_L0-1:0]           L0_CS;
    logic [Nums_L0-1:0]           L0_En_W;
    logic [Nums_L0-1:0]           L0_En_R;
    logic [L0_Addr_Width-1:0]     L0_Weight_Addr_Write;
    logic [L0_Addr_Width-1:0]     L0_Weight_Addr_Read;
    logic [L0_Addr_Width-1:0]     L0_Input_Addr_Write;
    logic [L0_Addr_Width-1:0]     L0_Input_Addr_Read;

    modport master (
        output Mem_Clear, Mem_CS, Mem_En_W, Mem_En_R,
        output Mem_Weight_Addr_Read, Mem_Input_Addr_Read, Mem_Output_Addr_Write,
        output L0_Clear, L0_CS, L0_En_W, L0_En_R,
        output L0_Weight_Addr_Write, L0_Weight_Addr_Read,
        output L0_Input_Addr_Write, L0_Input_Addr_Read
    );

    modport slave (
        input Mem_Clear, Mem_CS, Mem_En_W, Mem_En_R,
        input Mem_Weight_Addr_Read, Mem_Input_Addr_Read, Mem_Output_Addr_Write,
        input L0_Clear, L0_CS, L0_En_W, L0_En_R,
        input L0_Weight_Addr_Write, L0_Weight_Addr_Read,
        input L0_Input_Addr_Write, L0_Input_Addr_Read
    );

endinterface

// File: rtl/conv1d_loop_counter.sv
// Nested inner/outer loop counter: inner steps every cycle, outer steps when inner wraps.
module conv1d_loop_counter #(
    parameter int Inner_Nums  = 3,
    parameter int Outer_Nums  = 14,
    parameter int Inner_Width = 2,
    parameter int Outer_Width = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   step,
    output logic [Inner_Width-1:0] inner,
    output logic [Outer_Width-1:0] outer,
    output logic                   wrap,
    output logic                   last
);

    assign wrap = (inner == Inner_Width'(Inner_Nums - 1));
    assign last = wrap && (outer == Outer_Width'(Outer_Nums - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner <= '0;
            outer <= '0;
        end else if (clr) begin
            inner <= '0;
            outer <= '0;
        end else if (step) begin
            if (wrap) begin
                inner <= '0;
                outer <= last ? '0 : outer + 1'b1;
            end else begin
                inner <= inner + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv1d_mem_sequencer.sv
// Conv1D memory sequencer: issues SRAM reads, L0 ping-pong traffic and output writeback.
// Build option: SEQ_CLEAR_ON_START_EN adds a one-cycle CLEAR state before RUN.
//
//  state | meaning
//  IDLE  | waiting for Start
//  CLEAR | clear output SRAM and all L0 buffers (optional build)
//  RUN   | one weight/input issue per cycle, o outer, k inner
//  DRAIN | wait for pipeline tail and remaining writebacks
//  DONE  | one-cycle Done pulse
module conv1d_mem_sequencer
    import conv1d_pkg::*;
#(
    parameter int Weight_Nums       = 3,
    parameter int Input_Nums        = 16,
    parameter int Output_Nums       = Input_Nums - Weight_Nums + 1,
    parameter int Weight_Addr_Width = 2,
    parameter int Input_Addr_Width  = 4,
    parameter int Output_Addr_Width = 4,
    parameter int L0_Addr_Width     = 1,
    parameter int Nums_SRAM         = 3,
    parameter int Nums_L0           = 3
) (
    input  logic                clk,
    input  logic                Mem_Reset,
    input  logic                Start,
    input  logic                Acc_Valid,
    output logic                Busy,
    output logic                Done,
    output logic                Err,
    output logic                Mac_Valid,
    output logic                Mac_First,
    output logic                Mac_Last,
    conv1d_mem_sequencer_if.master mem
);

    localparam int WC_W = $clog2(Output_Nums + 1);

    seq_state_t state, state_nxt;

    logic [Weight_Addr_Width-1:0] k;
    logic [Output_Addr_Width-1:0] o;
    logic                         k_wrap;
    logic                         loop_last;

    logic start_ok, issue, acc_window, wb_fire, acc_over, tail_empty, clear_pulse;

    logic [PIPE_TAIL-1:0] pipe_v, pipe_first, pipe_last;
    logic                 p_bit, p_s1, p_s2;
    logic [WC_W-1:0]      wr_cnt;
    logic                 err_q;

    logic [Nums_SRAM-1:0] mem_clr, mem_cs, mem_en_w, mem_en_r;
    logic [Nums_L0-1:0]   l0_clr, l0_cs, l0_en_w, l0_en_r;

    assign start_ok   = (state == ST_IDLE) && Start;
    assign issue      = (state == ST_RUN);
    assign acc_window = (state == ST_RUN) || (state == ST_DRAIN);
    assign wb_fire    = Acc_Valid && acc_window && (wr_cnt != WC_W'(Output_Nums));
    assign acc_over   = Acc_Valid && acc_window && (wr_cnt == WC_W'(Output_Nums));
    assign tail_empty = ~|pipe_v;

`ifdef SEQ_CLEAR_ON_START_EN
    assign clear_pulse = (state == ST_CLEAR);
`else
    assign clear_pulse = 1'b0;
`endif

    conv1d_loop_counter #(
        .Inner_Nums  (Weight_Nums),
        .Outer_Nums  (Output_Nums),
        .Inner_Width (Weight_Addr_Width),
        .Outer_Width (Output_Addr_Width)
    ) u_loop (
        .clk   (clk),
        .rst_n (Mem_Reset),
        .clr   (start_ok),
        .step  (issue),
        .inner (k),
        .outer (o),
        .wrap  (k_wrap),
        .last  (loop_last)
    );

    always_ff @(posedge clk or negedge Mem_Reset) begin
        if (!Mem_Reset) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Start) begin
`ifdef SEQ_CLEAR_ON_START_EN
                    state_nxt = ST_CLEAR;
`else
                    state_nxt = ST_RUN;
`endif
                end
            end
            ST_CLEAR: state_nxt = ST_RUN;
            ST_RUN:   if (loop_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (tail_empty && (wr_cnt == WC_W'(Output_Nums))) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Stage 1 writes L0, stage 2 reads it, stage 3 presents data to the MAC
    always_ff @(posedge clk or negedge Mem_Reset) begin
        if (!Mem_Reset) begin
            pipe_v     <= '0;
            pipe_first <= '0;
            pipe_last  <= '0;
            p_bit      <= 1'b0;
            p_s1       <= 1'b0;
            p_s2       <= 1'b0;
        end else begin
            pipe_v     <= {pipe_v[PIPE_TAIL-2:0], issue};
            pipe_first <= {pipe_first[PIPE_TAIL-2:0], issue && (k == '0)};
            pipe_last  <= {pipe_last[PIPE_TAIL-2:0], issue && k_wrap};
            p_s1       <= p_bit;
            p_s2       <= p_s1;
            if (start_ok)   p_bit <= 1'b0;
            else if (issue) p_bit <= ~p_bit;
        end
    end

    always_ff @(posedge clk or negedge Mem_Reset) begin
        if (!Mem_Reset) begin
            wr_cnt <= '0;
            err_q  <= 1'b0;
        end else if (start_ok) begin
            wr_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wb_fire)  wr_cnt <= wr_cnt + 1'b1;
            if (acc_over) err_q  <= 1'b1;
        end
    end

    always_comb begin
        mem_clr  = '0;
        mem_cs   = '0;
        mem_en_w = '0;
        mem_en_r = '0;
        l0_clr   = '0;
        l0_cs    = '0;
        l0_en_w  = '0;
        l0_en_r  = '0;
        if (issue) begin
            mem_cs[IDX_WEIGHT]   = 1'b1;
            mem_cs[IDX_INPUT]    = 1'b1;
            mem_en_r[IDX_WEIGHT] = 1'b1;
            mem_en_r[IDX_INPUT]  = 1'b1;
        end
        if (wb_fire) begin
            mem_cs[IDX_OUTPUT]   = 1'b1;
            mem_en_w[IDX_OUTPUT] = 1'b1;
        end
        if (pipe_v[0]) begin
            l0_cs[IDX_WEIGHT]   = 1'b1;
            l0_cs[IDX_INPUT]    = 1'b1;
            l0_en_w[IDX_WEIGHT] = 1'b1;
            l0_en_w[IDX_INPUT]  = 1'b1;
        end
        // The L0 read also needs its chip-select
        if (pipe_v[1]) begin
            l0_cs[IDX_WEIGHT]   = 1'b1;
            l0_cs[IDX_INPUT]    = 1'b1;
            l0_en_r[IDX_WEIGHT] = 1'b1;
            l0_en_r[IDX_INPUT]  = 1'b1;
        end
        if (clear_pulse) begin
            mem_clr[IDX_OUTPUT] = 1'b1;
            l0_clr              = '1;
        end
    end

    assign mem.Mem_Clear             = mem_clr;
    assign mem.Mem_CS                = mem_cs;
    assign mem.Mem_En_W              = mem_en_w;
    assign mem.Mem_En_R              = mem_en_r;
    assign mem.Mem_Weight_Addr_Read  = k;
    assign mem.Mem_Input_Addr_Read   = Input_Addr_Width'(o) + Input_Addr_Width'(k);
    assign mem.Mem_Output_Addr_Write = Output_Addr_Width'(wr_cnt);
    assign mem.L0_Clear              = l0_clr;
    assign mem.L0_CS                 = l0_cs;
    assign mem.L0_En_W               = l0_en_w;
    assign mem.L0_En_R               = l0_en_r;
    assign mem.L0_Weight_Addr_Write  = L0_Addr_Width'(p_s1);
    assign mem.L0_Input_Addr_Write   = L0_Addr_Width'(p_s1);
    assign mem.L0_Weight_Addr_Read   = L0_Addr_Width'(p_s2);
    assign mem.L0_Input_Addr_Read    = L0_Addr_Width'(p_s2);

    assign Busy      = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_DRAIN);
    assign Done      = (state == ST_DONE);
    assign Err       = err_q;
    assign Mac_Valid = pipe_v[PIPE_TAIL-1];
    assign Mac_First = pipe_first[PIPE_TAIL-1];
    assign Mac_Last  = pipe_last[PIPE_TAIL-1];

endmodule

// File: tb/tb_conv1d_mem_sequencer.sv
// Scoreboard bench for conv1d_mem_sequencer: expected issues/writes queued at stimulus time.
module tb_conv1d_mem_sequencer;

    localparam int WN = 3;
    localparam int ON = 14;
`ifdef SEQ_CLEAR_ON_START_EN
    localparam int LAT = 2;
    localparam bit CLR_EN = 1'b1;
`else
    localparam int LAT = 1;
    localparam bit CLR_EN = 1'b0;
`endif

    typedef struct {
        int cyc;
        int w;
        int ia;
        int p;
        int first;
        int last;
    } iss_t;

    typedef struct {
        int wr;
        int addr;
    } wr_t;

    logic clk = 1'b0;
    logic Mem_Reset = 1'b0;
    logic Start = 1'b0;
    logic Acc_Valid = 1'b0;
    logic Busy, Done, Err, Mac_Valid, Mac_First, Mac_Last;

    conv1d_mem_sequencer_if mem_bus ();

    conv1d_mem_sequencer dut (
        .clk       (clk),
        .Mem_Reset (Mem_Reset),
        .Start     (Start),
        .Acc_Valid (Acc_Valid),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .Mac_Valid (Mac_Valid),
        .Mac_First (Mac_First),
        .Mac_Last  (Mac_Last),
        .mem       (mem_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;
    int done_cnt = 0;

    iss_t iss_q[$], l0w_q[$], l0r_q[$], mac_q[$];
    wr_t  wr_q[$];
    iss_t mon_r;
    wr_t  mon_w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({Busy, Done, Err, Mac_Valid, Mac_First, Mac_Last,
                    mem_bus.Mem_Clear, mem_bus.Mem_CS, mem_bus.Mem_En_W, mem_bus.Mem_En_R,
                    mem_bus.Mem_Weight_Addr_Read, mem_bus.Mem_Input_Addr_Read,
                    mem_bus.Mem_Output_Addr_Write,
                    mem_bus.L0_Clear, mem_bus.L0_CS, mem_bus.L0_En_W, mem_bus.L0_En_R,
                    mem_bus.L0_Weight_Addr_Write, mem_bus.L0_Weight_Addr_Read,
                    mem_bus.L0_Input_Addr_Write, mem_bus.L0_Input_Addr_Read});
    endfunction

    // Monitor: every DUT event pops its expected record
    always @(negedge clk) begin
        if (Mem_Reset) begin
            if (Done) done_cnt++;
            if (mem_bus.Mem_En_R[0]) begin
                if (iss_q.size() == 0) check("iss_extra", 1, 0);
                else begin
                    mon_r = iss_q.pop_front();
                    check("iss_cyc", cyc, mon_r.cyc);
                    check("iss_waddr", mem_bus.Mem_Weight_Addr_Read, mon_r.w);
                    check("iss_iaddr", mem_bus.Mem_Input_Addr_Read, mon_r.ia);
                    check("iss_en", {mem_bus.Mem_CS[1:0], mem_bus.Mem_En_R[1:0]}, 4'hf);
                end
            end
            if (mem_bus.L0_En_W[0]) begin
                if (l0w_q.size() == 0) check("l0w_extra", 1, 0);
                else begin
                    mon_r = l0w_q.pop_front();
                    check("l0w_cyc", cyc, mon_r.cyc + 1);
                    check("l0w_addr", {mem_bus.L0_Weight_Addr_Write, mem_bus.L0_Input_Addr_Write},
                          {mon_r.p[0], mon_r.p[0]});
                end
            end
            if (mem_bus.L0_En_R[0]) begin
                if (l0r_q.size() == 0) check("l0r_extra", 1, 0);
                else begin
                    mon_r = l0r_q.pop_front();
                    check("l0r_cyc", cyc, mon_r.cyc + 2);
                    check("l0r_addr", {mem_bus.L0_Weight_Addr_Read, mem_bus.L0_Input_Addr_Read},
                          {mon_r.p[0], mon_r.p[0]});
                end
            end
            if (Mac_Valid) begin
                if (mac_q.size() == 0) check("mac_extra", 1, 0);
                else begin
                    mon_r = mac_q.pop_front();
                    check("mac_cyc", cyc, mon_r.cyc + 3);
                    check("mac_first_last", {Mac_First, Mac_Last}, {mon_r.first[0], mon_r.last[0]});
                end
            end
            if (Acc_Valid) begin
                if (wr_q.size() == 0) check("wb_unexpected_acc", 1, 0);
                else begin
                    mon_w = wr_q.pop_front();
                    check("wb_en", {mem_bus.Mem_CS[2], mem_bus.Mem_En_W[2]},
                          mon_w.wr != 0 ? 2'b11 : 2'b00);
                    if (mon_w.wr != 0) check("wb_addr", mem_bus.Mem_Output_Addr_Write, mon_w.addr);
                end
            end else if (mem_bus.Mem_En_W[2]) begin
                check("wb_spurious", 1, 0);
            end
            if (mem_bus.Mem_En_R[2] || mem_bus.L0_CS[2] || mem_bus.L0_En_W[2] || mem_bus.L0_En_R[2])
                check("out_path_idle", 1, 0);
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(output int s0);
        iss_t r;
        @(posedge clk);
        #1;
        Start = 1'b1;
        s0 = cyc;
        done_cnt = 0;
        for (int o = 0; o < ON; o++) begin
            for (int k = 0; k < WN; k++) begin
                r.cyc   = s0 + LAT + o * WN + k;
                r.w     = k;
                r.ia    = o + k;
                r.p     = (o * WN + k) % 2;
                r.first = (k == 0) ? 1 : 0;
                r.last  = (k == WN - 1) ? 1 : 0;
                iss_q.push_back(r);
                l0w_q.push_back(r);
                l0r_q.push_back(r);
                mac_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        Start = 1'b0;
        @(negedge clk);
        check("busy_after_start", Busy, 1);
        check("err_cleared_by_start", Err, 0);
        check("mem_clear", mem_bus.Mem_Clear, CLR_EN ? 3'b100 : 3'b000);
        check("l0_clear", mem_bus.L0_Clear, CLR_EN ? 3'b111 : 3'b000);
    endtask

    task automatic acc_pulse(input int exp_wr, input int addr);
        wr_t w;
        w.wr = exp_wr;
        w.addr = addr;
        Acc_Valid = 1'b1;
        wr_q.push_back(w);
        @(posedge clk);
        #1;
        Acc_Valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        check("done_seen", done_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", Busy, 0);
        check("iss_left", iss_q.size(), 0);
        check("mac_left", mac_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
    endtask

    initial begin
        int s;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 0);
        Mem_Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_outputs", all_outs(), 0);

        // Run 1: 14 writebacks spaced 3 cycles, some landing in DRAIN
        do_start(s);
        for (int j = 0; j < ON; j++) begin
            wait_cyc(s + 6 + 3 * j);
            acc_pulse(1, j);
        end
        wait_done(200);
        check("err_run1", Err, 0);

        // Run 2: a 15th Acc_Valid beyond Output_Nums must not write and must set Err
        do_start(s);
        for (int j = 0; j <= ON; j++) begin
            wait_cyc(s + 2 + 2 * j);
            acc_pulse(j < ON ? 1 : 0, j);
        end
        wait_done(200);
        check("err_run2", Err, 1);
        acc_pulse(0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("err_sticky_idle", Err, 1);

        // Run 3: async reset in the middle of RUN
        do_start(s);
        wait_cyc(s + 21);
        Mem_Reset = 1'b0;
        iss_q.delete();
        l0w_q.delete();
        l0r_q.delete();
        mac_q.delete();
        wr_q.delete();
        @(negedge clk);
        check("midrun_reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        Mem_Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Run 4: restart from o=0,k=0, with a Start while busy that must be ignored
        do_start(s);
        wait_cyc(s + 10);
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        for (int j = 0; j < ON; j++) begin
            wait_cyc(s + 12 + 3 * j);
            acc_pulse(1, j);
        end
        wait_done(200);
        check("err_run4", Err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
